// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared definitions for the PLL lock supervisor.
//   - state encoding (S_RST..S_RUN) and its 3-bit width
//   - max4(): constant helper used to size the shared counters
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RST       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
//   clk  - destination clock
//   rst  - asynchronous active-high reset, both flops clear to 0
//   d    - asynchronous input
//   q    - synchronised output, 2 clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses the PLL reset, qualifies the (synchronised) lock,
// retries the PLL on lock timeout and releases NUM_CH downstream resets in a
// staggered order once lock is stable. Lock loss re-asserts every channel reset.
//
// Ports:
//   clkin         - reference clock (PLL input clock)
//   reset         - asynchronous active-high reset
//   pll_lock      - PLL lock, asynchronous to clkin
//   retry_req     - single-cycle request to force a PLL re-lock
//   pll_reset     - reset to the PLL
//   ch_reset      - per-channel reset, active-high
//   locked        - all channels released and lock qualified
//   timeout_err   - sticky: at least one lock timeout since the last lock
//   state         - current FSM state encoding
//   lock_loss_cnt - saturating lock-loss count (only with PLL_LOCK_LOSS_CNT_EN)
//
// Build option: define PLL_LOCK_LOSS_CNT_EN to add the lock_loss_cnt port.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 8,
  parameter int CNT_W            = 8
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               retry_req,
  output logic               pll_reset,
  output logic [NUM_CH-1:0]  ch_reset,
  output logic               locked,
  output logic               timeout_err,
  output logic [STATE_W-1:0] state
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0]   lock_loss_cnt
`endif
);

  localparam int CNT_MAX = max4(LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC,
                                NUM_CH * STAGGER_CYC, RST_PULSE_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CNT_TOP) ? x : x + 1'b1;
  endfunction

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;    // pulse / stable / release counter, per state
  logic [CW-1:0]     tcnt_q, tcnt_d;  // lock timeout, survives STABLE->WAIT bounces
  logic              pll_reset_q, pll_reset_d;
  logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;
  logic              locked_q, locked_d;
  logic              timeout_err_q, timeout_err_d;
  logic              retry_hit, timeout_hit, lock_lost;

  // retry is ignored while already in S_RST so the pulse is never stretched
  assign retry_hit   = retry_req && (state_q != S_RST);
  assign timeout_hit = (state_q == S_WAIT_LOCK) && !lock_s && (tcnt_q == TMO_LAST);
  assign lock_lost   = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !lock_s
                       && !retry_hit;

  // state register
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (retry_hit) begin
      state_d = S_RST;
    end else begin
      case (state_q)
        S_RST:       if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: if (lock_s)            state_d = S_STABLE;
                     else if (timeout_hit)  state_d = S_RST;
        S_STABLE:    if (!lock_s)           state_d = S_WAIT_LOCK;
                     else if (cnt_q == STB_LAST) state_d = S_RELEASE;
        S_RELEASE:   if (!lock_s)           state_d = S_WAIT_LOCK;
                     else if (!ch_reset_q[NUM_CH-1]) state_d = S_RUN;
        S_RUN:       if (!lock_s)           state_d = S_WAIT_LOCK;
        default:                            state_d = S_RST;
      endcase
    end
  end

  // registered outputs and counters
  always_comb begin
    // per-state counter restarts from 0 on every state change
    cnt_d = '0;
    if (state_d == state_q && state_q inside {S_RST, S_STABLE, S_RELEASE})
      cnt_d = sat_inc(cnt_q);

    tcnt_d = '0;
    if (state_q == S_WAIT_LOCK)   tcnt_d = sat_inc(tcnt_q);
    else if (state_q == S_STABLE) tcnt_d = tcnt_q;
    if (state_d == S_RST || state_d == S_RELEASE) tcnt_d = '0;

    pll_reset_d = (state_d == S_RST);

    ch_reset_d = ch_reset_q;
    if (state_d inside {S_RST, S_WAIT_LOCK, S_STABLE}) begin
      ch_reset_d = '1;
    end else if (state_q == S_RELEASE) begin
      // channel i drops the cycle after the release counter hits i*STAGGER_CYC
      for (int i = 0; i < NUM_CH; i++)
        if (cnt_q == CW'(i * STAGGER_CYC)) ch_reset_d[i] = 1'b0;
    end

    locked_d = (state_d == S_RUN);

    timeout_err_d = timeout_err_q;
    if (timeout_hit && !retry_hit)                timeout_err_d = 1'b1;
    if (state_d == S_RUN && state_q != S_RUN)     timeout_err_d = 1'b0;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      tcnt_q        <= '0;
      pll_reset_q   <= 1'b1;
      ch_reset_q    <= '1;
      locked_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      pll_reset_q   <= pll_reset_d;
      ch_reset_q    <= ch_reset_d;
      locked_q      <= locked_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign ch_reset    = ch_reset_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_err_q;
  assign state       = state_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] llc_q, llc_d;

  always_comb begin
    llc_d = llc_q;
    if (lock_lost && llc_q != '1) llc_d = llc_q + 1'b1;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) llc_q <= '0;
    else       llc_q <= llc_d;
  end

  assign lock_loss_cnt = llc_q;
`else
  // counter absent; keep the width parameter and loss strobe referenced
  logic [CNT_W-1:0] unused_llc;
  logic             unused_lock_lost;
  assign unused_llc       = '0;
  assign unused_lock_lost = lock_lost;
`endif

endmodule
